spi_flash_write_loader: RTL and testbench

- Upstream feeder for spi_flash_write.
- Receives a framed byte stream from a UART receiver (byte plus one-cycle strobe) and parses a header that gives mode, start address and length.
- Buffers the whole payload in on-chip RAM, then fires the pi_flag launch pulse.
- Streams write_data one byte per clock, gap-free, exactly as spi_flash_write samples it.
- Holds its parameters stable until write_finish returns.

---
 rtl/spi_flash_pkg.sv | 31 +++
 rtl/spi_flash_write_loader_if.sv | 32 +++
 rtl/spi_flash_write_loader_buf_ram.sv | 31 +++
 rtl/spi_flash_write_loader.sv | 250 +++++++++++++++++++++++++
 tb/tb_spi_flash_write_loader.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_flash_pkg.sv
// -----------------------------------------------------------------------------
// spi_flash_pkg
// Shared definitions for the SPI flash write loader: FSM state encoding,
// frame constants, flash program mode encodings and the header sanity check.
// -----------------------------------------------------------------------------
package spi_flash_pkg;

   typedef enum logic [2:0] {
      ST_HUNT   = 3'd0,
      ST_HDR    = 3'd1,
      ST_LOAD   = 3'd2,
      ST_LAUNCH = 3'd3,
      ST_STREAM = 3'd4,
      ST_WAIT   = 3'd5
   } state_e;

   localparam logic [7:0]  SYNC_BYTE = 8'hA5;
   localparam int unsigned HDR_LEN   = 7;
   localparam logic        MODE_PP   = 1'b0;
   localparam logic        MODE_PPX4 = 1'b1;

   // A header is usable when the reserved mode bits are clear and the length
   // is non-zero and fits the payload buffer (compared on the full 16 bits).
   function automatic logic hdr_valid(input logic [7:0]  mode_byte,
                                      input logic [15:0] len,
                                      input logic [16:0] max_bytes);
      return (mode_byte[7:1] == 7'd0) && (len != 16'd0) &&
             ({1'b0, len} <= max_bytes);
   endfunction

endpackage

// File: rtl/spi_flash_write_loader_if.sv
// -----------------------------------------------------------------------------
// spi_flash_write_loader_if
// Bundles the UART byte input, the spi_flash_write handshake and the status
// outputs of the loader.
//   master : the environment (UART receiver + spi_flash_write side)
//   slave  : the loader itself
// -----------------------------------------------------------------------------
interface spi_flash_write_loader_if;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        write_finish;
   logic        pi_flag;
   logic [7:0]  write_data;
   logic [15:0] write_num;
   logic [31:0] write_start_addr;
   logic        mode;
   logic        busy;
   logic        frame_err;
   logic        rx_drop;

   modport master (
      output rx_data, rx_valid, write_finish,
      input  pi_flag, write_data, write_num, write_start_addr, mode,
             busy, frame_err, rx_drop
   );

   modport slave (
      input  rx_data, rx_valid, write_finish,
      output pi_flag, write_data, write_num, write_start_addr, mode,
             busy, frame_err, rx_drop
   );
endinterface

// File: rtl/spi_flash_write_loader_buf_ram.sv
// -----------------------------------------------------------------------------
// loader_buf_ram
// Simple dual-port synchronous RAM, DEPTH x 8, one write and one read port,
// registered read data (1-cycle latency). Contents are not reset.
//   clk   : clock
//   we    : write enable,  waddr/wdata : write port
//   raddr : read address,  rdata       : read data, valid one cycle later
// -----------------------------------------------------------------------------
module loader_buf_ram #(
   parameter int unsigned DEPTH = 8192,
   parameter int unsigned AW    = 13
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [7:0]    wdata,
   input  logic [AW-1:0] raddr,
   output logic [7:0]    rdata
);

   logic [7:0] mem [DEPTH];

   // Write port and registered read port.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
      rdata <= mem[raddr];
   end

endmodule

// File: rtl/spi_flash_write_loader.sv
// -----------------------------------------------------------------------------
// spi_flash_write_loader
// Parses a framed UART byte stream (sync, mode, addr[31:0], len[15:0],
// payload), buffers the payload, pulses pi_flag and streams the payload
// gap-free to spi_flash_write, holding its parameters until write_finish.
//   system_clk      : clock
//   system_reset_n  : asynchronous active-low reset
//   bus (slave)     : rx_data/rx_valid in, write_finish in, pi_flag,
//                     write_data, write_num, write_start_addr, mode, busy,
//                     frame_err, rx_drop out (all registered)
// -----------------------------------------------------------------------------
module spi_flash_write_loader
   import spi_flash_pkg::*;
#(
   parameter int unsigned MAX_BYTES  = 8192,
   parameter int unsigned BUF_AW     = 13,
   parameter int unsigned PI_PULSE   = 2,
   parameter int unsigned RX_TIMEOUT = 500000
) (
   input logic                      system_clk,
   input logic                      system_reset_n,
   spi_flash_write_loader_if.slave  bus
);

   localparam logic [2:0] HDR_LAST = 3'(HDR_LEN - 1);

   state_e      state_q, state_d;
   logic [2:0]  hdr_cnt_q, hdr_cnt_d;
   logic [7:0]  mode_byte_q, mode_byte_d;
   logic [31:0] addr_q, addr_d;
   logic [15:0] len_q, len_d;
   logic [15:0] pay_cnt_q, pay_cnt_d;
   logic [15:0] rd_cnt_q, rd_cnt_d;
   logic [31:0] idle_q, idle_d;
   logic [7:0]  pulse_cnt_q, pulse_cnt_d;
   logic        pi_flag_q, pi_flag_d;
   logic [7:0]  write_data_q, write_data_d;
   logic [15:0] write_num_q, write_num_d;
   logic [31:0] write_start_addr_q, write_start_addr_d;
   logic        mode_q, mode_d;
   logic        busy_q, busy_d;
   logic        frame_err_q, frame_err_d;
   logic        rx_drop_q, rx_drop_d;

   logic        ram_we;
   logic [7:0]  ram_rdata;
   logic        sync_seen, hdr_last, hdr_ok, load_last, timeout;
   logic        pulse_last, stream_last;
   logic [15:0] len_full;

   assign sync_seen   = bus.rx_valid && (bus.rx_data == SYNC_BYTE);
   assign hdr_last    = bus.rx_valid && (hdr_cnt_q == HDR_LAST);
   assign len_full    = {len_q[7:0], bus.rx_data};
   assign hdr_ok      = hdr_valid(mode_byte_q, len_full, 17'(MAX_BYTES));
   assign load_last   = bus.rx_valid && (pay_cnt_q == (len_q - 16'd1));
   assign timeout     = !bus.rx_valid && (idle_q == 32'(RX_TIMEOUT - 1));
   assign pulse_last  = (pulse_cnt_q == 8'(PI_PULSE - 1));
   // rd_cnt runs one ahead of the byte on write_data, so reaching len means
   // the last byte is currently being presented.
   assign stream_last = (rd_cnt_q == len_q);

   // Read address follows the next read count so the registered RAM output
   // already holds the byte needed on the following edge.
   loader_buf_ram #(.DEPTH(MAX_BYTES), .AW(BUF_AW)) u_buf (
      .clk   (system_clk),
      .we    (ram_we),
      .waddr (pay_cnt_q[BUF_AW-1:0]),
      .wdata (bus.rx_data),
      .raddr (rd_cnt_d[BUF_AW-1:0]),
      .rdata (ram_rdata)
   );

   // State register and all datapath/output flops.
   always_ff @(posedge system_clk or negedge system_reset_n) begin
      if (!system_reset_n) begin
         state_q            <= ST_HUNT;
         hdr_cnt_q          <= 3'd0;
         mode_byte_q        <= 8'd0;
         addr_q             <= 32'd0;
         len_q              <= 16'd0;
         pay_cnt_q          <= 16'd0;
         rd_cnt_q           <= 16'd0;
         idle_q             <= 32'd0;
         pulse_cnt_q        <= 8'd0;
         pi_flag_q          <= 1'b0;
         write_data_q       <= 8'd0;
         write_num_q        <= 16'd0;
         write_start_addr_q <= 32'd0;
         mode_q             <= 1'b0;
         busy_q             <= 1'b0;
         frame_err_q        <= 1'b0;
         rx_drop_q          <= 1'b0;
      end else begin
         state_q            <= state_d;
         hdr_cnt_q          <= hdr_cnt_d;
         mode_byte_q        <= mode_byte_d;
         addr_q             <= addr_d;
         len_q              <= len_d;
         pay_cnt_q          <= pay_cnt_d;
         rd_cnt_q           <= rd_cnt_d;
         idle_q             <= idle_d;
         pulse_cnt_q        <= pulse_cnt_d;
         pi_flag_q          <= pi_flag_d;
         write_data_q       <= write_data_d;
         write_num_q        <= write_num_d;
         write_start_addr_q <= write_start_addr_d;
         mode_q             <= mode_d;
         busy_q             <= busy_d;
         frame_err_q        <= frame_err_d;
         rx_drop_q          <= rx_drop_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_HUNT:   state_d = sync_seen ? ST_HDR : ST_HUNT;
         ST_HDR:    if (timeout)       state_d = ST_HUNT;
                    else if (hdr_last) state_d = hdr_ok ? ST_LOAD : ST_HUNT;
                    else               state_d = ST_HDR;
         ST_LOAD:   if (timeout)        state_d = ST_HUNT;
                    else if (load_last) state_d = ST_LAUNCH;
                    else                state_d = ST_LOAD;
         ST_LAUNCH: state_d = pulse_last ? ST_STREAM : ST_LAUNCH;
         ST_STREAM: state_d = stream_last ? ST_WAIT : ST_STREAM;
         ST_WAIT:   state_d = bus.write_finish ? ST_HUNT : ST_WAIT;
         default:   state_d = ST_HUNT;
      endcase
   end

   // Datapath and output logic.
   always_comb begin
      hdr_cnt_d          = hdr_cnt_q;
      mode_byte_d        = mode_byte_q;
      addr_d             = addr_q;
      len_d              = len_q;
      pay_cnt_d          = pay_cnt_q;
      rd_cnt_d           = rd_cnt_q;
      idle_d             = idle_q;
      pulse_cnt_d        = pulse_cnt_q;
      pi_flag_d          = 1'b0;
      write_data_d       = 8'd0;
      write_num_d        = write_num_q;
      write_start_addr_d = write_start_addr_q;
      mode_d             = mode_q;
      busy_d             = busy_q;
      frame_err_d        = 1'b0;
      rx_drop_d          = 1'b0;
      ram_we             = 1'b0;
      case (state_q)
         ST_HUNT: begin
            hdr_cnt_d          = 3'd0;
            pay_cnt_d          = 16'd0;
            rd_cnt_d           = 16'd0;
            idle_d             = 32'd0;
            pulse_cnt_d        = 8'd0;
            write_num_d        = 16'd0;
            write_start_addr_d = 32'd0;
            mode_d             = MODE_PP;
            busy_d             = sync_seen;
         end
         ST_HDR: begin
            if (bus.rx_valid) begin
               idle_d    = 32'd0;
               hdr_cnt_d = hdr_cnt_q + 3'd1;
               if (hdr_cnt_q == 3'd0) begin
                  mode_byte_d = bus.rx_data;
               end else if (hdr_cnt_q <= 3'd4) begin
                  addr_d = {addr_q[23:0], bus.rx_data};
               end else begin
                  len_d = len_full;
               end
               frame_err_d = hdr_last && !hdr_ok;
               busy_d      = !(hdr_last && !hdr_ok);
            end else begin
               idle_d      = idle_q + 32'd1;
               frame_err_d = timeout;
               busy_d      = !timeout;
            end
         end
         ST_LOAD: begin
            if (bus.rx_valid) begin
               ram_we    = 1'b1;
               idle_d    = 32'd0;
               pay_cnt_d = pay_cnt_q + 16'd1;
               if (load_last) begin
                  // Launch: parameters become visible with the first pi_flag cycle.
                  pi_flag_d          = 1'b1;
                  pulse_cnt_d        = 8'd0;
                  rd_cnt_d           = 16'd0;
                  write_num_d        = len_q;
                  write_start_addr_d = addr_q;
                  mode_d             = mode_byte_q[0] ? MODE_PPX4 : MODE_PP;
               end else begin
                  pi_flag_d = 1'b0;
               end
            end else begin
               idle_d      = idle_q + 32'd1;
               frame_err_d = timeout;
               busy_d      = !timeout;
            end
         end
         ST_LAUNCH: begin
            rx_drop_d = bus.rx_valid;
            if (pulse_last) begin
               // Byte 0 was prefetched during the pulse.
               write_data_d = ram_rdata;
               rd_cnt_d     = 16'd1;
            end else begin
               pi_flag_d   = 1'b1;
               pulse_cnt_d = pulse_cnt_q + 8'd1;
            end
         end
         ST_STREAM: begin
            rx_drop_d = bus.rx_valid;
            if (stream_last) begin
               write_data_d = 8'd0;
            end else begin
               write_data_d = ram_rdata;
               rd_cnt_d     = rd_cnt_q + 16'd1;
            end
         end
         ST_WAIT: begin
            rx_drop_d = bus.rx_valid;
            if (bus.write_finish) begin
               busy_d             = 1'b0;
               write_num_d        = 16'd0;
               write_start_addr_d = 32'd0;
               mode_d             = MODE_PP;
            end else begin
               busy_d = 1'b1;
            end
         end
         default: begin
            busy_d = 1'b0;
         end
      endcase
   end

   assign bus.pi_flag          = pi_flag_q;
   assign bus.write_data       = write_data_q;
   assign bus.write_num        = write_num_q;
   assign bus.write_start_addr = write_start_addr_q;
   assign bus.mode             = mode_q;
   assign bus.busy             = busy_q;
   assign bus.frame_err        = frame_err_q;
   assign bus.rx_drop          = rx_drop_q;

endmodule

// File: tb/tb_spi_flash_write_loader.sv
// -----------------------------------------------------------------------------
// tb_spi_flash_write_loader
// Self-checking bench: a table of frames plus randomized frames driven through
// the UART-side inputs, with a negedge monitor recording what the loader
// launches and streams; expectations come from the frame contents themselves.
// -----------------------------------------------------------------------------
module tb_spi_flash_write_loader;

   localparam int unsigned MAX_BYTES = 8192;
   localparam int unsigned PI_PULSE  = 2;
   localparam int unsigned RX_TO     = 100;
   localparam logic [7:0]  SYNC      = 8'hA5;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   spi_flash_write_loader_if bus_if();

   spi_flash_write_loader #(
      .MAX_BYTES (MAX_BYTES),
      .BUF_AW    (13),
      .PI_PULSE  (PI_PULSE),
      .RX_TIMEOUT(RX_TO)
   ) dut (
      .system_clk     (clk),
      .system_reset_n (rst_n),
      .bus            (bus_if)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
      end
   endtask

   // ---------------- monitor ----------------
   logic        pi_prev   = 1'b0;
   int          pi_run    = 0;
   int          pi_runs[$];
   int          launches  = 0;
   logic [15:0] cap_num   = 16'd0;
   logic [31:0] cap_addr  = 32'd0;
   logic        cap_mode  = 1'b0;
   bit          streaming = 1'b0;
   bit          hold      = 1'b0;
   int          str_idx   = 0;
   int          str_len   = 0;
   logic [7:0]  got_q[$];
   int          fe_cnt    = 0;
   int          drop_cnt  = 0;

   initial begin
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            pi_prev = 1'b0; pi_run = 0; streaming = 1'b0; hold = 1'b0;
         end else begin
            if (bus_if.frame_err) fe_cnt++;
            if (bus_if.rx_drop)   drop_cnt++;
            if (!bus_if.busy) hold = 1'b0;
            else if (hold) begin
               check("hold_write_num", bus_if.write_num, cap_num);
               check("hold_addr", bus_if.write_start_addr, cap_addr);
               check("hold_mode", bus_if.mode, cap_mode);
            end
            if (bus_if.pi_flag && !pi_prev) begin
               launches++;
               cap_num = bus_if.write_num; cap_addr = bus_if.write_start_addr;
               cap_mode = bus_if.mode; hold = 1'b1;
            end
            if (bus_if.pi_flag) pi_run++;
            if (!bus_if.pi_flag && pi_prev) begin
               pi_runs.push_back(pi_run); pi_run = 0;
               streaming = 1'b1; str_idx = 0; str_len = int'(cap_num);
            end
            if (streaming) begin
               if (str_idx < str_len) got_q.push_back(bus_if.write_data);
               else begin
                  check("data_zero_after_stream", bus_if.write_data, 32'd0);
                  streaming = 1'b0;
               end
               str_idx++;
            end
            pi_prev = bus_if.pi_flag;
         end
      end
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   task automatic send_byte(input logic [7:0] b);
      bus_if.rx_data = b; bus_if.rx_valid = 1'b1;
      tick();
      bus_if.rx_valid = 1'b0; bus_if.rx_data = 8'd0;
   endtask

   task automatic send_gap(input logic [7:0] b);
      if ($urandom_range(0, 3) == 0) tick();
      send_byte(b);
   endtask

   task automatic send_hdr_body(input logic [7:0] mb, input logic [31:0] addr, input logic [15:0] len);
      send_gap(mb);
      send_gap(addr[31:24]); send_gap(addr[23:16]); send_gap(addr[15:8]); send_gap(addr[7:0]);
      send_gap(len[15:8]); send_gap(len[7:0]);
   endtask

   // Reference rule for whether a header is accepted.
   function automatic bit model_ok(input logic [7:0] mb, input logic [15:0] len);
      return (mb[7:1] == 7'd0) && (len != 16'd0) && (int'(len) <= MAX_BYTES);
   endfunction

   function automatic logic [7:0] pay_byte(input int kind, input int i);
      if (kind == 0) return 8'(i);
      else if (kind == 1) return 8'(3 * i);
      else return 8'($urandom);
   endfunction

   task automatic run_frame(input logic [7:0] mb, input logic [31:0] addr, input logic [15:0] len,
                            input int kind, input int drops, input bit exp_ok, input string tag);
      logic [7:0] pay[$];
      int fe0, la0, dr0, n, left, bad;
      for (int i = 0; i < int'(len); i++) pay.push_back(pay_byte(kind, i));
      fe0 = fe_cnt; la0 = launches; dr0 = drop_cnt;
      got_q.delete(); pi_runs.delete();
      send_byte(SYNC);
      check({tag, "_busy_after_sync"}, bus_if.busy, 32'd1);
      send_hdr_body(mb, addr, len);
      if (!exp_ok) begin
         idle(3);
         check({tag, "_frame_err_pulses"}, fe_cnt - fe0, 32'd1);
         check({tag, "_no_launch"}, launches - la0, 32'd0);
         check({tag, "_busy_low"}, bus_if.busy, 32'd0);
         return;
      end
      foreach (pay[i]) send_gap(pay[i]);
      n = 0; left = drops;
      while (!(got_q.size() == int'(len) && !streaming) && n < int'(len) + 50) begin
         if (streaming && left > 0 && $urandom_range(0, 3) == 0) begin
            bus_if.rx_data = 8'($urandom); bus_if.rx_valid = 1'b1; left--;
         end
         tick();
         bus_if.rx_valid = 1'b0;
         n++;
      end
      check({tag, "_stream_done_in_time"}, n < int'(len) + 50, 32'd1);
      while (left > 0) begin send_byte(8'($urandom)); left--; end
      idle(2);
      check({tag, "_pi_pulses"}, pi_runs.size(), 32'd1);
      if (pi_runs.size() > 0) check({tag, "_pi_width"}, pi_runs[0], PI_PULSE);
      check({tag, "_launches"}, launches - la0, 32'd1);
      check({tag, "_write_num"}, cap_num, len);
      check({tag, "_addr"}, cap_addr, addr);
      check({tag, "_mode"}, cap_mode, mb[0]);
      check({tag, "_stream_len"}, got_q.size(), len);
      bad = 0;
      for (int i = 0; i < int'(len) && i < got_q.size(); i++) if (got_q[i] !== pay[i]) bad++;
      check({tag, "_stream_byte_mismatches"}, bad, 32'd0);
      if (got_q.size() == int'(len)) check({tag, "_last_byte"}, got_q[len - 1], pay[len - 1]);
      check({tag, "_rx_drop_pulses"}, drop_cnt - dr0, drops);
      check({tag, "_no_frame_err"}, fe_cnt - fe0, 32'd0);
      idle($urandom_range(0, 4));
      check({tag, "_busy_in_wait"}, bus_if.busy, 32'd1);
      bus_if.write_finish = 1'b1;
      tick();
      bus_if.write_finish = 1'b0;
      check({tag, "_busy_after_finish"}, bus_if.busy, 32'd0);
      check({tag, "_num_cleared"}, bus_if.write_num, 32'd0);
      check({tag, "_addr_cleared"}, bus_if.write_start_addr, 32'd0);
      check({tag, "_mode_cleared"}, bus_if.mode, 32'd0);
   endtask

   typedef struct {
      logic [7:0]  mode_b;
      logic [31:0] addr;
      logic [15:0] len;
      int          kind;
      int          drops;
      bit          exp_ok;
   } vec_t;

   localparam int NV = 9;
   vec_t vecs[NV];

   initial begin
      int fe0, la0, n, pi_hi;
      logic [7:0] mb;
      logic [15:0] ln;

      vecs[0] = '{8'h00, 32'h0000_0000, 16'd512,    0, 0, 1'b1};
      vecs[1] = '{8'h01, 32'h0000_2000, 16'd2048,   1, 0, 1'b1};
      vecs[2] = '{8'h00, 32'h0000_0100, 16'd0,      0, 0, 1'b0};
      vecs[3] = '{8'h00, 32'h0000_0100, 16'h2001,   0, 0, 1'b0};
      vecs[4] = '{8'h00, 32'hDEAD_BEEF, 16'd16,     2, 0, 1'b1};
      vecs[5] = '{8'h02, 32'h0000_0000, 16'd4,      2, 0, 1'b0};
      vecs[6] = '{8'h01, 32'h1234_5678, 16'd300,    2, 5, 1'b1};
      vecs[7] = '{8'h00, 32'h0001_0000, 16'd8192,   2, 0, 1'b1};
      vecs[8] = '{8'h01, 32'h0000_00FF, 16'd1,      2, 0, 1'b1};

      bus_if.rx_data = 8'd0; bus_if.rx_valid = 1'b0; bus_if.write_finish = 1'b0;
      rst_n = 1'b0;
      idle(3);
      rst_n = 1'b1;
      tick();
      check("reset_pi_flag", bus_if.pi_flag, 32'd0);
      check("reset_write_data", bus_if.write_data, 32'd0);
      check("reset_write_num", bus_if.write_num, 32'd0);
      check("reset_addr", bus_if.write_start_addr, 32'd0);
      check("reset_mode", bus_if.mode, 32'd0);
      check("reset_busy", bus_if.busy, 32'd0);
      check("reset_frame_err", bus_if.frame_err, 32'd0);
      check("reset_rx_drop", bus_if.rx_drop, 32'd0);

      // Non-sync bytes in HUNT are ignored.
      send_byte(8'h5A); send_byte(8'h00);
      idle(1);
      check("hunt_ignores_busy", bus_if.busy, 32'd0);

      for (int v = 0; v < NV; v++)
         run_frame(vecs[v].mode_b, vecs[v].addr, vecs[v].len, vecs[v].kind,
                   vecs[v].drops, vecs[v].exp_ok, $sformatf("vec%0d", v));

      // Header stalls after three address bytes.
      fe0 = fe_cnt; la0 = launches;
      send_byte(SYNC); send_byte(8'h00);
      send_byte(8'h00); send_byte(8'h00); send_byte(8'h10);
      n = 0;
      while (n < 200) begin
         tick(); n++;
         if (bus_if.frame_err) break;
      end
      check("timeout_cycles", n, RX_TO);
      check("timeout_busy_low", bus_if.busy, 32'd0);
      idle(2);
      check("timeout_frame_err_pulses", fe_cnt - fe0, 32'd1);
      check("timeout_no_launch", launches - la0, 32'd0);
      run_frame(8'h00, 32'h0000_4000, 16'd20, 0, 0, 1'b1, "after_timeout");

      // Reset halfway through streaming a 5120-byte frame.
      got_q.delete();
      send_byte(SYNC);
      send_hdr_body(8'h01, 32'h00AB_CD00, 16'd5120);
      for (int i = 0; i < 5120; i++) send_gap(8'($urandom));
      n = 0;
      while (got_q.size() < 2560 && n < 3000) begin tick(); n++; end
      check("rst_mid_reached_half", got_q.size() >= 2560, 32'd1);
      rst_n = 1'b0;
      #1;
      check("rst_mid_pi_flag", bus_if.pi_flag, 32'd0);
      check("rst_mid_write_data", bus_if.write_data, 32'd0);
      check("rst_mid_write_num", bus_if.write_num, 32'd0);
      check("rst_mid_addr", bus_if.write_start_addr, 32'd0);
      check("rst_mid_mode", bus_if.mode, 32'd0);
      check("rst_mid_busy", bus_if.busy, 32'd0);
      idle(2);
      rst_n = 1'b1;
      pi_hi = 0;
      repeat (20) begin tick(); if (bus_if.pi_flag) pi_hi++; end
      check("rst_mid_pi_stays_low", pi_hi, 32'd0);
      run_frame(8'h00, 32'h0000_0800, 16'd64, 0, 0, 1'b1, "after_reset");

      // Randomized frames judged by the reference rule.
      for (int r = 0; r < 6; r++) begin
         mb = ($urandom_range(0, 5) == 0) ? 8'h80 : 8'($urandom_range(0, 1));
         ln = 16'($urandom_range(0, 40));
         run_frame(mb, $urandom, ln, 2, $urandom_range(0, 3), model_ok(mb, ln),
                   $sformatf("rand%0d", r));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
